// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Produces registered sync, blanking, display-enable, pixel coordinates and
// line/frame start pulses for an arbitrary raster geometry. The counters
// advance only on clock edges where pix_en_i is high. Every output is decoded
// from the *next* counter values and registered, so all outputs change
// together on the same advancing edge.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b0,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   block_clk_i,
  input  logic                   rst_high_i,
  input  logic                   pix_en_i,
  output logic                   h_sync_o,
  output logic                   v_sync_o,
  output logic                   de_o,
  output logic                   h_blank_o,
  output logic                   v_blank_o,
  output logic [COUNT_WIDTH-1:0] x_o,
  output logic [COUNT_WIDTH-1:0] y_o,
  output logic                   line_start_o,
  output logic                   frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW1     = COUNT_WIDTH + 1;

  // Reject geometries that cannot be represented or make no sense.
  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
      H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0 ||
      COUNT_WIDTH < 1 || COUNT_WIDTH > 30 ||
      H_TOTAL > (1 << COUNT_WIDTH) || V_TOTAL > (1 << COUNT_WIDTH)) begin : g_bad_params
    $error("vga_timing_gen: illegal raster geometry or COUNT_WIDTH too small");
  end

  // Last count of each axis; the counters wrap from here back to zero.
  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);

  // Region boundaries carry one extra bit so a sync region ending exactly at
  // 2**COUNT_WIDTH (zero back porch, full-width total) still compares right.
  localparam logic [CW1-1:0] H_ACT_END  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] H_SYNC_BEG = CW1'(H_ACTIVE + H_FRONT);
  localparam logic [CW1-1:0] H_SYNC_END = CW1'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW1-1:0] V_ACT_END  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] V_SYNC_BEG = CW1'(V_ACTIVE + V_FRONT);
  localparam logic [CW1-1:0] V_SYNC_END = CW1'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [COUNT_WIDTH-1:0] h_cnt, v_cnt;
  logic [COUNT_WIDTH-1:0] h_nxt, v_nxt;
  logic [CW1-1:0]         h_ext, v_ext;
  logic                   h_wrap;
  logic                   h_blank_nxt, v_blank_nxt;
  logic                   h_sync_act, v_sync_act;

  // Next counter values and the decode of those values into output levels.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + COUNT_WIDTH'(1);
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + COUNT_WIDTH'(1);
    end

    h_ext       = {1'b0, h_nxt};
    v_ext       = {1'b0, v_nxt};
    h_blank_nxt = (h_ext >= H_ACT_END);
    v_blank_nxt = (v_ext >= V_ACT_END);
    h_sync_act  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_sync_act  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
  end

  // Counter state and registered outputs, all updated on advancing edges.
  always_ff @(posedge block_clk_i or posedge rst_high_i) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the outputs below see a consistent snapshot.
    if (rst_high_i) begin
      // Counters park on the last position so the first advance lands on (0,0).
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      x_o           <= '0;
      y_o           <= '0;
      de_o          <= 1'b0;
      h_blank_o     <= 1'b1;
      v_blank_o     <= 1'b1;
      h_sync_o      <= ~H_SYNC_POL;
      v_sync_o      <= ~V_SYNC_POL;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      // Pulses last one clock regardless of how long pix_en_i stays low.
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (pix_en_i) begin
        h_cnt         <= h_nxt;
        v_cnt         <= v_nxt;
        x_o           <= h_nxt;
        y_o           <= v_nxt;
        h_blank_o     <= h_blank_nxt;
        v_blank_o     <= v_blank_nxt;
        de_o          <= ~h_blank_nxt & ~v_blank_nxt;
        h_sync_o      <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync_o      <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
        line_start_o  <= (h_nxt == '0);
        frame_start_o <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three geometries (default, default
// horizontal with a short frame, and a tiny positive-polarity raster) share
// clock, reset and pix_en. The expected outputs come from a position-based
// model: the n-th enabled edge after reset sits at raster position n-1.
module tb_vga_timing_gen;

  typedef struct packed {
    int   ha, hf, hs, hb, va, vf, vs, vb;
    logic hpol, vpol;
  } geom_t;

  typedef struct packed {
    logic [9:0] x, y;
    logic de, hblk, vblk, hsync, vsync, ls, fs;
  } obs_t;

  typedef struct packed {
    obs_t d, m, s;
  } trio_t;

  localparam geom_t G_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam geom_t G_MID = '{640, 16, 96, 48,   6,  2, 2,  2, 1'b0, 1'b0};
  localparam geom_t G_SML = '{  8,  2,  3,  1,   4,  1, 1,  1, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  logic       d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       m_hs, m_vs, m_de, m_hb, m_vb, m_ls, m_fs;
  logic [9:0] m_x, m_y;
  logic       s_hs, s_vs, s_de, s_hb, s_vb, s_ls, s_fs;
  logic [3:0] s_x, s_y;

  int    checks = 0;
  int    errors = 0;
  int    k = 0;
  int    n_pushed = 0;
  int    n_popped = 0;
  trio_t exp_q[$];

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .block_clk_i(clk), .rst_high_i(rst), .pix_en_i(pix_en),
    .h_sync_o(d_hs), .v_sync_o(d_vs), .de_o(d_de), .h_blank_o(d_hb),
    .v_blank_o(d_vb), .x_o(d_x), .y_o(d_y), .line_start_o(d_ls),
    .frame_start_o(d_fs)
  );

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_mid (
    .block_clk_i(clk), .rst_high_i(rst), .pix_en_i(pix_en),
    .h_sync_o(m_hs), .v_sync_o(m_vs), .de_o(m_de), .h_blank_o(m_hb),
    .v_blank_o(m_vb), .x_o(m_x), .y_o(m_y), .line_start_o(m_ls),
    .frame_start_o(m_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COUNT_WIDTH(4)
  ) u_sml (
    .block_clk_i(clk), .rst_high_i(rst), .pix_en_i(pix_en),
    .h_sync_o(s_hs), .v_sync_o(s_vs), .de_o(s_de), .h_blank_o(s_hb),
    .v_blank_o(s_vb), .x_o(s_x), .y_o(s_y), .line_start_o(s_ls),
    .frame_start_o(s_fs)
  );

  // Expected outputs after the k-th enabled edge since reset (k=0: reset state).
  function automatic obs_t model(input geom_t g, input int kk, input bit adv);
    obs_t o;
    int   ht, vt, flat, x, y;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    if (kk == 0) begin
      o = '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, ~g.hpol, ~g.vpol, 1'b0, 1'b0};
      return o;
    end
    flat    = (kk - 1) % (ht * vt);
    x       = flat % ht;
    y       = flat / ht;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hblk  = (x >= g.ha);
    o.vblk  = (y >= g.va);
    o.de    = (x < g.ha) && (y < g.va);
    o.hsync = (x >= g.ha + g.hf && x < g.ha + g.hf + g.hs) ? g.hpol : ~g.hpol;
    o.vsync = (y >= g.va + g.vf && y < g.va + g.vf + g.vs) ? g.vpol : ~g.vpol;
    o.ls    = adv && (x == 0);
    o.fs    = adv && (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t act_def();
    return '{d_x, d_y, d_de, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs};
  endfunction

  function automatic obs_t act_mid();
    return '{m_x, m_y, m_de, m_hb, m_vb, m_hs, m_vs, m_ls, m_fs};
  endfunction

  function automatic obs_t act_sml();
    return '{10'(s_x), 10'(s_y), s_de, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got x=%0d y=%0d de=%b hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d de=%b hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b",
               name, $time, act.x, act.y, act.de, act.hblk, act.vblk, act.hsync,
               act.vsync, act.ls, act.fs, exp.x, exp.y, exp.de, exp.hblk,
               exp.vblk, exp.hsync, exp.vsync, exp.ls, exp.fs);
    end
  endtask

  // One clock of stimulus; the expected response is queued after the edge.
  task automatic step(input logic pen);
    bit adv;
    pix_en = pen;
    @(posedge clk);
    adv = 1'b0;
    if (rst) begin
      k = 0;
    end else if (pen) begin
      k++;
      adv = 1'b1;
    end
    exp_q.push_back('{model(G_DEF, k, adv), model(G_MID, k, adv), model(G_SML, k, adv)});
    n_pushed++;
    @(negedge clk);
  endtask

  // Monitor: compares queued expectations on the falling edge.
  initial begin
    trio_t t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        n_popped++;
        check("def", act_def(), t.d);
        check("mid", act_mid(), t.m);
        check("sml", act_sml(), t.s);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;

    // Continuous enable: covers a full short frame and many tiny frames.
    repeat (10000) step(1'b1);

    // Enable on every fourth clock: periods stretch, pulses stay one clock.
    for (int i = 0; i < 20000; i++) step(i % 4 == 3);

    // Random enable pattern.
    repeat (10000) step(1'($urandom_range(0, 1)));

    // Reset asserted between clock edges must take effect immediately.
    #2 rst = 1'b1;
    #1;
    check("async_rst_def", act_def(), model(G_DEF, 0, 1'b0));
    check("async_rst_mid", act_mid(), model(G_MID, 0, 1'b0));
    check("async_rst_sml", act_sml(), model(G_SML, 0, 1'b0));
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    // Release with enable low first: the first enabled edge enters (0,0).
    step(1'b0);
    step(1'b0);
    repeat (12000) step(1'b1);

    repeat (3) @(negedge clk);
    checks++;
    if (n_popped != n_pushed) begin
      errors++;
      $display("FAIL drain: got %0d compared, expected %0d", n_popped, n_pushed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
